spi_sclk_gen: RTL and testbench

Parametrised SPI serial-clock generator for the SPI controller. It produces a finite burst of SCLK edges for one frame, with a runtime-programmable divisor, bit count, CPOL and CPHA. Alongside SCLK it outputs one-cycle sample and shift strobes, so the shift-register datapath never has to decode SCLK itself. It sits between the controller FSM, which drives config and start, and the MOSI/MISO shifter, which consumes the strobes.

---
 rtl/spi_sclk_gen.sv | 131 +++++++++++++
 tb/tb_spi_sclk_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: emits a finite burst of SCLK edges per frame
// plus registered lead/trail edge pulses and CPHA-mapped sample/shift strobes.
module spi_sclk_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_wr,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic [CNT_W-1:0] i_cfg_bits,
  input  logic             i_cfg_cpol,
  input  logic             i_cfg_cpha,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sclk,
  output logic             o_lead_edge,
  output logic             o_trail_edge,
  output logic             o_sample,
  output logic             o_shift,
  output logic [CNT_W-1:0] o_bit_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] bits_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [DIV_W-1:0] fast_cnt;
  logic [CNT_W:0]   edge_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             sclk_q;
  logic             lead_q;
  logic             trail_q;

  logic             half_done;
  logic [CNT_W:0]   edge_next;
  logic             last_edge;
  logic             going_lead;

  // div_q never holds 0 (a zero write is stored as 1), so H-1 never underflows.
  assign half_done  = (fast_cnt == div_q - DIV_W'(1));
  assign edge_next  = edge_cnt + (CNT_W+1)'(1);
  assign last_edge  = (edge_next == {bits_q, 1'b0});
  assign going_lead = (sclk_q == cpol_q);

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values of state, counters and sclk_q within the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      div_q    <= DIV_W'(2);
      bits_q   <= CNT_W'(8);
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      fast_cnt <= '0;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      sclk_q   <= 1'b0;
      lead_q   <= 1'b0;
      trail_q  <= 1'b0;
    end else begin
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          sclk_q <= cpol_q;
          if (i_cfg_wr) begin
            div_q  <= (i_cfg_div == '0) ? DIV_W'(1) : i_cfg_div;
            bits_q <= i_cfg_bits;
            cpol_q <= i_cfg_cpol;
            cpha_q <= i_cfg_cpha;
            // Bypass so a new idle level appears one cycle after the write.
            sclk_q <= i_cfg_cpol;
          end else if (i_start) begin
            if (bits_q != '0) begin
              state    <= ST_RUN;
              fast_cnt <= '0;
              edge_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            state  <= ST_IDLE;
            sclk_q <= cpol_q;
          end else if (half_done) begin
            fast_cnt <= '0;
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_next;
            lead_q   <= going_lead;
            trail_q  <= ~going_lead;
            if (!going_lead) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (last_edge) begin
              state <= ST_DONE;
            end
          end else begin
            fast_cnt <= fast_cnt + DIV_W'(1);
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          sclk_q <= cpol_q;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = (state == ST_RUN);
  assign o_done       = (state == ST_DONE);
  assign o_sclk       = sclk_q;
  assign o_lead_edge  = lead_q;
  assign o_trail_edge = trail_q;
  // CPHA only swaps which edge pulse drives which strobe.
  assign o_sample     = cpha_q ? trail_q : lead_q;
  assign o_shift      = cpha_q ? lead_q  : trail_q;
  assign o_bit_count  = bit_cnt;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: a timeline model (outputs derived from the cycle
// offset within a frame) compared every cycle, plus directed literal checks.
module tb_spi_sclk_gen;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cfg_wr = 1'b0;
  logic [7:0] i_cfg_div = '0;
  logic [5:0] i_cfg_bits = '0;
  logic       i_cfg_cpol = 1'b0;
  logic       i_cfg_cpha = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic       o_busy, o_done, o_sclk, o_lead_edge, o_trail_edge, o_sample, o_shift;
  logic [5:0] o_bit_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  spi_sclk_gen #(.DIV_W(8), .CNT_W(6)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_cfg_wr     (i_cfg_wr),
    .i_cfg_div    (i_cfg_div),
    .i_cfg_bits   (i_cfg_bits),
    .i_cfg_cpol   (i_cfg_cpol),
    .i_cfg_cpha   (i_cfg_cpha),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_sclk       (o_sclk),
    .o_lead_edge  (o_lead_edge),
    .o_trail_edge (o_trail_edge),
    .o_sample     (o_sample),
    .o_shift      (o_shift),
    .o_bit_count  (o_bit_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: config, plus "frame in progress at cycle offset m_off" (1..2NH+1).
  int   m_h    = 2;
  int   m_bits = 8;
  bit   m_cpol = 1'b0;
  bit   m_cpha = 1'b0;
  bit   m_run  = 1'b0;
  int   m_off  = 0;
  int   m_held = 0;
  bit   m_zdone = 1'b0;
  bit   m_idle;

  initial forever begin
    @(posedge i_clk or negedge i_rst_n);
    if (!i_rst_n) begin
      m_h = 2; m_bits = 8; m_cpol = 1'b0; m_cpha = 1'b0;
      m_run = 1'b0; m_off = 0; m_held = 0; m_zdone = 1'b0;
    end else begin
      m_idle  = !m_run && !m_zdone;
      m_zdone = 1'b0;
      if (m_run) begin
        if (m_off == 2 * m_bits * m_h + 1) begin
          m_run  = 1'b0;
          m_held = m_bits;
        end else if (i_abort) begin
          m_run  = 1'b0;
          m_held = ((m_off - 1) / m_h) / 2;
        end else begin
          m_off++;
        end
      end else if (m_idle) begin
        if (i_cfg_wr) begin
          m_h    = (i_cfg_div == 8'd0) ? 1 : int'(i_cfg_div);
          m_bits = int'(i_cfg_bits);
          m_cpol = i_cfg_cpol;
          m_cpha = i_cfg_cpha;
        end else if (i_start) begin
          if (m_bits != 0) begin
            m_run = 1'b1;
            m_off = 1;
          end else begin
            m_zdone = 1'b1;
          end
        end
      end
    end
  end

  typedef struct packed {
    logic       busy, done, sclk, lead, trail, sample, shift;
    logic [5:0] bc;
  } obs_t;

  function automatic obs_t model_expect();
    obs_t o;
    int   e;
    bit   p;
    o      = '0;
    o.sclk = m_cpol;
    o.bc   = 6'(m_held);
    o.done = m_zdone;
    if (m_run) begin
      e       = (m_off - 1) / m_h;
      p       = (m_off > 1) && ((m_off - 1) % m_h == 0);
      o.busy  = (m_off <= 2 * m_bits * m_h);
      o.done  = (m_off == 2 * m_bits * m_h + 1);
      o.sclk  = m_cpol ^ e[0];
      o.lead  = p && e[0];
      o.trail = p && !e[0];
      o.bc    = 6'(e / 2);
    end
    o.sample = m_cpha ? o.trail : o.lead;
    o.shift  = m_cpha ? o.lead  : o.trail;
    return o;
  endfunction

  always @(negedge i_clk) begin
    obs_t x;
    if (i_rst_n === 1'b1) begin
      x = model_expect();
      check("cyc_busy",   int'(o_busy),       int'(x.busy));
      check("cyc_done",   int'(o_done),       int'(x.done));
      check("cyc_sclk",   int'(o_sclk),       int'(x.sclk));
      check("cyc_lead",   int'(o_lead_edge),  int'(x.lead));
      check("cyc_trail",  int'(o_trail_edge), int'(x.trail));
      check("cyc_sample", int'(o_sample),     int'(x.sample));
      check("cyc_shift",  int'(o_shift),      int'(x.shift));
      check("cyc_bitcnt", int'(o_bit_count),  int'(x.bc));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic cfg(input int div, input int bits, input bit cpol, input bit cpha);
    i_cfg_wr = 1'b1; i_cfg_div = 8'(div); i_cfg_bits = 6'(bits);
    i_cfg_cpol = cpol; i_cfg_cpha = cpha;
    step(1);
    i_cfg_wr = 1'b0;
  endtask

  // Start is high in cycle 0; returns in the middle of cycle 1.
  task automatic start();
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  initial begin
    step(3);
    #1 i_rst_n = 1'b1;
    step(1);
    check("rst_busy",   int'(o_busy), 0);
    check("rst_sclk",   int'(o_sclk), 0);
    check("rst_bitcnt", int'(o_bit_count), 0);
    check("rst_done",   int'(o_done), 0);

    // Basic frame: H=2, N=8, mode 0.
    cfg(2, 8, 1'b0, 1'b0);
    start();
    step(2);
    check("basic_c3_sclk",   int'(o_sclk), 1);
    check("basic_c3_sample", int'(o_sample), 1);
    step(2);
    check("basic_c5_sclk",  int'(o_sclk), 0);
    check("basic_c5_shift", int'(o_shift), 1);
    step(27);
    check("basic_c32_busy", int'(o_busy), 1);
    step(1);
    check("basic_c33_done",   int'(o_done), 1);
    check("basic_c33_bitcnt", int'(o_bit_count), 8);
    check("basic_c33_busy",   int'(o_busy), 0);
    step(1);
    check("basic_c34_done", int'(o_done), 0);

    // Mode 3 at H=1: idles high, toggles cycles 2..9.
    cfg(1, 4, 1'b1, 1'b1);
    check("mode_cpol_idle", int'(o_sclk), 1);
    start();
    step(1);
    check("mode_c2_sclk",   int'(o_sclk), 0);
    check("mode_c2_shift",  int'(o_shift), 1);
    check("mode_c2_sample", int'(o_sample), 0);
    step(1);
    check("mode_c3_sample", int'(o_sample), 1);
    step(6);
    check("mode_c9_done", int'(o_done), 1);
    check("mode_c9_sclk", int'(o_sclk), 1);
    step(1);

    // div=0 behaves as div=1.
    cfg(0, 3, 1'b0, 1'b0);
    start();
    step(1);
    check("div0_c2_lead", int'(o_lead_edge), 1);
    step(5);
    check("div0_c7_done", int'(o_done), 1);
    step(1);

    // div=255, one bit.
    cfg(255, 1, 1'b0, 1'b0);
    start();
    step(255);
    check("div255_c256_lead", int'(o_lead_edge), 1);
    step(255);
    check("div255_c511_trail", int'(o_trail_edge), 1);
    check("div255_c511_done",  int'(o_done), 1);
    step(1);

    // bits=0: immediate done, never busy.
    cfg(3, 0, 1'b0, 1'b0);
    start();
    check("bits0_c1_done", int'(o_done), 1);
    check("bits0_c1_busy", int'(o_busy), 0);
    step(1);

    // cfg_wr together with start: config taken, no frame.
    i_cfg_wr = 1'b1; i_cfg_div = 8'd1; i_cfg_bits = 6'd2; i_cfg_cpol = 1'b1; i_cfg_cpha = 1'b0;
    i_start = 1'b1;
    step(1);
    i_cfg_wr = 1'b0; i_start = 1'b0;
    check("coll_busy", int'(o_busy), 0);
    check("coll_sclk", int'(o_sclk), 1);
    step(1);

    // cfg_wr during RUN is ignored.
    cfg(2, 8, 1'b0, 1'b0);
    start();
    step(4);
    i_cfg_wr = 1'b1; i_cfg_div = 8'd1; i_cfg_bits = 6'd1; i_cfg_cpol = 1'b1;
    step(1);
    i_cfg_wr = 1'b0;
    step(27);
    check("runwr_c33_done",   int'(o_done), 1);
    check("runwr_c33_bitcnt", int'(o_bit_count), 8);
    step(1);

    // Abort in cycle 10.
    start();
    step(9);
    i_abort = 1'b1;
    step(1);
    i_abort = 1'b0;
    check("abort_c11_busy",   int'(o_busy), 0);
    check("abort_c11_sclk",   int'(o_sclk), 0);
    check("abort_c11_bitcnt", int'(o_bit_count), 2);
    check("abort_c11_done",   int'(o_done), 0);
    step(25);

    // Abort coincident with the final edge.
    cfg(1, 2, 1'b0, 1'b0);
    start();
    step(3);
    i_abort = 1'b1;
    step(1);
    i_abort = 1'b0;
    check("abortlast_done",   int'(o_done), 0);
    check("abortlast_bitcnt", int'(o_bit_count), 1);
    step(2);

    // Asynchronous reset mid-frame, then a frame with the reset config.
    cfg(2, 6, 1'b0, 1'b1);
    start();
    step(19);
    check("pre_rst_sclk",   int'(o_sclk), 1);
    check("pre_rst_bitcnt", int'(o_bit_count), 4);
    #1 i_rst_n = 1'b0;
    #1;
    check("async_rst_busy",   int'(o_busy), 0);
    check("async_rst_sclk",   int'(o_sclk), 0);
    check("async_rst_bitcnt", int'(o_bit_count), 0);
    check("async_rst_done",   int'(o_done), 0);
    check("async_rst_pulse",  int'({o_lead_edge, o_trail_edge}), 0);
    step(1);
    #1 i_rst_n = 1'b1;
    step(1);
    start();
    step(2);
    check("restart_c3_sclk", int'(o_sclk), 1);
    step(30);
    check("restart_c33_done",   int'(o_done), 1);
    check("restart_c33_bitcnt", int'(o_bit_count), 8);
    step(1);

    // Random traffic against the model.
    repeat (3000) begin
      i_start    = ($urandom_range(0, 3) == 0);
      i_cfg_wr   = ($urandom_range(0, 19) == 0);
      i_abort    = ($urandom_range(0, 59) == 0);
      i_cfg_div  = 8'($urandom_range(0, 4));
      i_cfg_bits = 6'($urandom_range(0, 6));
      i_cfg_cpol = 1'($urandom_range(0, 1));
      i_cfg_cpha = 1'($urandom_range(0, 1));
      step(1);
    end
    i_start = 1'b0; i_cfg_wr = 1'b0; i_abort = 1'b0;
    step(60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
